// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the divider requester and its watchdog.
//   state_e       - requester FSM encoding (3 bits)
//   SEL_CH1/CH2   - divider Select values for the two measurement channels
//   DIV_WIDTH     - default quotient width, matching the divider
package div_pkg;

  localparam int DIV_WIDTH = 12;

  localparam logic SEL_CH1 = 1'b1;
  localparam logic SEL_CH2 = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

endpackage

// File: rtl/div_watchdog.sv
// div_watchdog: per-phase cycle counter for the divider requester.
// Counts cycles while en is high and clears whenever clr is high. expire is
// raised combinationally on the TIMEOUT-th consecutive enabled cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          return the count to zero (takes priority over en)
//   en           count this cycle
//   expire       this is the TIMEOUT-th enabled cycle since the last clear
module div_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clr && (cnt_q == LIMIT);

endmodule

// File: rtl/div_requester.sv
// div_requester: drives the sequential divider's en/Select/Busy/Ready
// handshake on behalf of the measurement control logic. One pass divides
// channel 1 (Select=1) and then channel 2 (Select=0), each only if enabled
// in chan_mask, and publishes each quotient with a one-cycle update strobe.
//
// Optional feature: define DIVREQ_TIMEOUT_EN to add a per-phase watchdog
// (div_watchdog) that abandons a pass stuck in ISSUE or WAIT for TIMEOUT
// cycles and strobes err. Without it err is tied low and the FSM waits
// indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request a pass (level, sampled every cycle)
//   chan_mask[1:0]    bit0 = channel 1, bit1 = channel 2, sampled at pass start
//   div_busy          divider Busy
//   div_ready         divider Ready
//   div_res           divider quotient
//   div_en            divider en
//   div_select        divider Select (1 = channel 1, 0 = channel 2)
//   res1, res2        last quotient of each channel, held
//   upd1, upd2        one-cycle strobe when res1 / res2 is written
//   done              one-cycle strobe at the end of a pass
//   active            high from pass start until done
//   err               one-cycle strobe on watchdog abort
module div_requester
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       chan_mask,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_res,
  output logic             div_en,
  output logic             div_select,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  output logic             upd1,
  output logic             upd2,
  output logic             done,
  output logic             active,
  output logic             err
);

  if ((2 ** TO_W) <= TIMEOUT) begin : g_to_w_check
    $error("div_requester: TO_W too narrow for TIMEOUT");
  end

  state_e           state_q, state_d;
  logic             ch2_en_q, ch2_en_d;   // channel 2 still to run in this pass
  logic             pending_q, pending_d;
  logic             active_q, active_d;
  logic             div_en_q, div_en_d;
  logic             div_sel_q, div_sel_d; // also identifies the current channel
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic             upd1_q, upd1_d;
  logic             upd2_q, upd2_d;
  logic             done_q, done_d;

`ifdef DIVREQ_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  // The counter runs only in ISSUE/WAIT. Every exit other than expiry is
  // listed here so the count restarts on each state change; after an expiry
  // the FSM sits in FINISH, which is outside ISSUE/WAIT and clears it.
  assign wd_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign wd_clr = !wd_en
               || ((state_q == ST_ISSUE) && div_busy)
               || ((state_q == ST_WAIT) && div_ready && !div_busy);

  div_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );
`endif

  always_comb begin
    state_d   = state_q;
    ch2_en_d  = ch2_en_q;
    pending_d = pending_q;
    active_d  = active_q;
    div_en_d  = div_en_q;
    div_sel_d = div_sel_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    upd1_d    = 1'b0;
    upd2_d    = 1'b0;
    done_d    = 1'b0;
`ifdef DIVREQ_TIMEOUT_EN
    err_d     = 1'b0;
`endif

    // Requests during a pass coalesce into one re-run.
    if (start && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start || pending_q) begin
          pending_d = 1'b0;
          if (chan_mask != 2'b00) begin
            ch2_en_d  = chan_mask[1];
            div_sel_d = chan_mask[0] ? SEL_CH1 : SEL_CH2;
            div_en_d  = 1'b1;
            active_d  = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            // Empty mask: no divider traffic, just report completion.
            state_d = ST_FINISH;
          end
        end
      end

      ST_ISSUE: begin
        // Ready is ignored here: it may still be high from the previous
        // operation until the divider raises Busy for this one.
        if (div_busy) begin
          state_d = ST_WAIT;
        end
`ifdef DIVREQ_TIMEOUT_EN
        else if (wd_expire) begin
          err_d    = 1'b1;
          div_en_d = 1'b0;
          state_d  = ST_FINISH;
        end
`endif
      end

      ST_WAIT: begin
        // Ready together with Busy is not yet a finished result.
        if (div_ready && !div_busy) begin
          div_en_d = 1'b0;
          state_d  = ST_CAPTURE;
          if (div_sel_q == SEL_CH1) begin
            res1_d = div_res;
            upd1_d = 1'b1;
          end else begin
            res2_d = div_res;
            upd2_d = 1'b1;
          end
        end
`ifdef DIVREQ_TIMEOUT_EN
        else if (wd_expire) begin
          err_d    = 1'b1;
          div_en_d = 1'b0;
          state_d  = ST_FINISH;
        end
`endif
      end

      ST_CAPTURE: begin
        if ((div_sel_q == SEL_CH1) && ch2_en_q) begin
          // Switch Select now so it is settled before en rises again.
          div_sel_d = SEL_CH2;
          state_d   = ST_GAP;
        end else begin
          state_d = ST_FINISH;
        end
      end

      ST_GAP: begin
        div_en_d = 1'b1;
        state_d  = ST_ISSUE;
      end

      ST_FINISH: begin
        done_d   = 1'b1;
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        div_en_d = 1'b0;
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch2_en_q  <= 1'b0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      div_en_q  <= 1'b0;
      div_sel_q <= SEL_CH1;
      res1_q    <= '0;
      res2_q    <= '0;
      upd1_q    <= 1'b0;
      upd2_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch2_en_q  <= ch2_en_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      div_en_q  <= div_en_d;
      div_sel_q <= div_sel_d;
      res1_q    <= res1_d;
      res2_q    <= res2_d;
      upd1_q    <= upd1_d;
      upd2_q    <= upd2_d;
      done_q    <= done_d;
    end
  end

`ifdef DIVREQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign div_en     = div_en_q;
  assign div_select = div_sel_q;
  assign res1       = res1_q;
  assign res2       = res2_q;
  assign upd1       = upd1_q;
  assign upd2       = upd2_q;
  assign done       = done_q;
  assign active     = active_q;

endmodule

// File: tb/tb_div_requester.sv
// tb_div_requester: scoreboard bench for div_requester driving a behavioural
// model of the sequential divider (one-cycle waiting-clear after en, Busy for
// a fixed latency, one cycle of Ready overlapping Busy with a junk result,
// Ready then held until the next operation starts).
module tb_div_requester;
  import div_pkg::*;

  localparam int W = 12;
`ifdef DIVREQ_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 255;
`endif
  localparam int DIV_LAT = 8;

  localparam int K_UPD1 = 1;
  localparam int K_UPD2 = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   chan_mask = 2'b00;
  logic         div_busy = 1'b0;
  logic         div_ready = 1'b0;
  logic [W-1:0] div_res = '0;
  logic         div_en, div_select, upd1, upd2, done, active, err;
  logic [W-1:0] res1, res2;

  always #5 clk = ~clk;

  div_requester #(
    .WIDTH   (W),
    .TIMEOUT (TMO),
    .TO_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chan_mask  (chan_mask),
    .div_busy   (div_busy),
    .div_ready  (div_ready),
    .div_res    (div_res),
    .div_en     (div_en),
    .div_select (div_select),
    .res1       (res1),
    .res2       (res2),
    .upd1       (upd1),
    .upd2       (upd2),
    .done       (done),
    .active     (active),
    .err        (err)
  );

  // Divider model
  logic [W-1:0] a1 = '0, b1 = 12'd1, a2 = '0, b2 = 12'd1;
  logic [W-1:0] qv = '0;
  logic         stub_mode = 1'b0;
  int           dst = 0;
  int           dcnt = 0;

  function automatic logic [W-1:0] quot(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '0 : a / b;
  endfunction

  always @(posedge clk) begin
    if (stub_mode) begin
      div_busy  <= 1'b0;
      div_ready <= 1'b0;
      dst       <= 0;
    end else if (!div_en) begin
      div_busy <= 1'b0;
      dst      <= 0;
    end else begin
      case (dst)
        0: dst <= 1;
        1: begin
          div_busy  <= 1'b1;
          div_ready <= 1'b0;
          qv        <= div_select ? quot(a1, b1) : quot(a2, b2);
          dcnt      <= DIV_LAT;
          dst       <= 2;
        end
        2: begin
          if (dcnt == 1) begin
            div_ready <= 1'b1;
            div_res   <= 12'hABC;
            dst       <= 3;
          end else begin
            dcnt <= dcnt - 1;
          end
        end
        3: begin
          div_busy <= 1'b0;
          div_res  <= qv;
          dst      <= 4;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard
  typedef struct {
    int           kind;
    logic [W-1:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_err = 0;
  logic sel_watch = 1'b0;
  logic sel_exp = 1'b1;
  int  sel_bad = 0;
  int  en_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = W'(v);
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input logic [W-1:0] v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d, required none", k, v);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (e.val !== v)) begin
        n_err++;
        $display("FAIL event: got kind=%0d val=%0d, required kind=%0d val=%0d",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (upd1) begin
        got(K_UPD1, res1);
        chk("active_at_upd1", 32'(active), 1);
      end
      if (upd2) begin
        got(K_UPD2, res2);
        chk("active_at_upd2", 32'(active), 1);
      end
      if (err) got(K_ERR, '0);
      if (done) begin
        got(K_DONE, '0);
        chk("active_at_done", 32'(active), 0);
      end
      if (sel_watch && div_en && (div_select != sel_exp)) sel_bad++;
      if (div_en) en_cnt++;
    end
  end

  task automatic pulse_start(input logic [1:0] mask);
    @(negedge clk);
    chan_mask = mask;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_div_en", 32'(div_en), 0);
    chk("rst_div_select", 32'(div_select), 1);
    chk("rst_res1", 32'(res1), 0);
    chk("rst_res2", 32'(res2), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_strobes", {28'd0, upd1, upd2, done, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both channels: 100/7 and 4095/1
    a1 = 12'd100; b1 = 12'd7; a2 = 12'd4095; b2 = 12'd1;
    push(K_UPD1, 14); push(K_UPD2, 4095); push(K_DONE, 0);
    pulse_start(2'b11);
    wait_drain("pass_both", 300);

    // Channel 1 divide by zero, Select must stay 1
    a1 = 12'd55; b1 = 12'd0;
    sel_exp = 1'b1; sel_bad = 0; sel_watch = 1'b1;
    push(K_UPD1, 0); push(K_DONE, 0);
    pulse_start(2'b01);
    wait_drain("pass_div0", 300);
    sel_watch = 1'b0;
    chk("div0_select_held", 32'(sel_bad), 0);
    chk("div0_res2_kept", 32'(res2), 4095);

    // Three starts during a pass coalesce into exactly one re-run
    a1 = 12'd20; b1 = 12'd5; a2 = 12'd30; b2 = 12'd6;
    push(K_UPD1, 4); push(K_UPD2, 5); push(K_DONE, 0);
    push(K_UPD1, 4); push(K_UPD2, 5); push(K_DONE, 0);
    pulse_start(2'b11);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_drain("pass_coalesce", 800);
    en_cnt = 0;
    repeat (60) @(negedge clk);
    chk("coalesce_no_third_pass", 32'(en_cnt), 0);
    chk("coalesce_idle", 32'(active), 0);

    // Reset while channel 2 is in WAIT
    a1 = 12'd100; b1 = 12'd7; a2 = 12'd4095; b2 = 12'd1;
    push(K_UPD1, 14);
    pulse_start(2'b11);
    wait_drain("reset_pass_upd1", 300);
    n = 0;
    while (!(div_busy && !div_select) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("reach_ch2_wait", 32'(n < 200), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_res1", 32'(res1), 0);
    chk("midrst_res2", 32'(res2), 0);
    chk("midrst_div_en", 32'(div_en), 0);
    chk("midrst_div_select", 32'(div_select), 1);
    chk("midrst_active", 32'(active), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a1 = 12'd9; b1 = 12'd3; a2 = 12'd8; b2 = 12'd2;
    push(K_UPD1, 3); push(K_UPD2, 4); push(K_DONE, 0);
    pulse_start(2'b11);
    wait_drain("pass_after_reset", 300);

    // Channel 2 only, Select must stay 0 while en is high
    a2 = 12'd60; b2 = 12'd4;
    sel_exp = 1'b0; sel_bad = 0; sel_watch = 1'b1;
    push(K_UPD2, 15); push(K_DONE, 0);
    pulse_start(2'b10);
    wait_drain("pass_ch2_only", 300);
    sel_watch = 1'b0;
    chk("ch2_select_held", 32'(sel_bad), 0);
    chk("ch2_res1_kept", 32'(res1), 3);

    // Empty mask: done only, no divider activity
    en_cnt = 0;
    push(K_DONE, 0);
    pulse_start(2'b00);
    wait_drain("pass_empty_mask", 20);
    chk("empty_mask_no_en", 32'(en_cnt), 0);

`ifdef DIVREQ_TIMEOUT_EN
    // Busy stuck low: watchdog abort after TMO ISSUE cycles
    stub_mode = 1'b1;
    en_cnt = 0;
    push(K_ERR, 0); push(K_DONE, 0);
    pulse_start(2'b01);
    wait_drain("pass_timeout", 100);
    chk("timeout_issue_cycles", 32'(en_cnt), 32'(TMO));
    chk("timeout_res1_kept", 32'(res1), 3);
    chk("timeout_div_en_low", 32'(div_en), 0);
    stub_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
